// File: rtl/des_encrypt_core.sv
// -----------------------------------------------------------------------------
// des_encrypt_core
//   Iterative single-key DES encryptor (FIPS 46-3). It computes one Feistel
//   round per clock. The key is fixed at build time through the KEY parameter.
//   There is no decrypt path.
//
//   Handshake: start is a level request. It is only looked at in IDLE. At that
//   edge plain_text is captured. Exactly 17 clocks later cipher_text updates and
//   dat_valid is high for that single cycle. cipher_text then holds until the
//   next result. With start held high, operations run back-to-back every 18
//   clocks.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst_n        in   1   synchronous reset, active HIGH despite the name
//   plain_text   in   64  plaintext, DES bit 1 = [63], bit 64 = [0]
//   start        in   1   operation request, sampled only in IDLE
//   cipher_text  out  64  ciphertext, same bit order, held between results
//   dat_valid    out  1   one-cycle strobe coinciding with a cipher_text update
// -----------------------------------------------------------------------------
module des_encrypt_core #(
    parameter logic [63:0] KEY = 64'h133457799BBCDFF1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] plain_text,
    input  logic        start,
    output logic [63:0] cipher_text,
    output logic        dat_valid
);

    // Tables use the FIPS numbering: entry value n means DES bit n (1 = MSB).
    localparam int IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_TBL [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // SBOX[box][row*16 + col]
    localparam logic [3:0] SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_TBL[i])];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_TBL[i])];
        return y;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_TBL[i])];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_TBL[i])];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_TBL[i])];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_TBL[i])];
        return y;
    endfunction

    // Each 6-bit group selects row = {b1,b6}, column = b2..b5.
    function automatic logic [31:0] sbox_sub(input logic [47:0] x);
        logic [31:0] y;
        logic [5:0]  six;
        y = '0;
        for (int b = 0; b < 8; b++) begin
            six = 6'(x >> (42 - 6 * b));
            y   = y | (32'(SBOX[3'(b)][{six[5], six[0], six[4:1]}]) << (28 - 4 * b));
        end
        return y;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  round;
    logic [31:0] l_reg, r_reg;
    logic [27:0] c_reg, d_reg;

    logic        single_shift;
    logic [27:0] c_rot, d_rot;
    logic [47:0] round_key;
    logic [31:0] f_out;

    // Round function for the round number currently held in `round`.
    always_comb begin
        single_shift = (round == 5'd1) || (round == 5'd2) ||
                       (round == 5'd9) || (round == 5'd16);
        if (single_shift) begin
            c_rot = {c_reg[26:0], c_reg[27]};
            d_rot = {d_reg[26:0], d_reg[27]};
        end else begin
            c_rot = {c_reg[25:0], c_reg[27:26]};
            d_rot = {d_reg[25:0], d_reg[27:26]};
        end
        round_key = pc2_perm({c_rot, d_rot});
        f_out     = p_perm(sbox_sub(e_expand(r_reg) ^ round_key));
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state       <= IDLE;
            round       <= 5'd0;
            l_reg       <= '0;
            r_reg       <= '0;
            c_reg       <= '0;
            d_reg       <= '0;
            cipher_text <= '0;
            dat_valid   <= 1'b0;
        end else begin
            dat_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // An X on start falls into the else branch, so no operation begins.
                    if (start == 1'b1) begin
                        {l_reg, r_reg} <= ip_perm(plain_text);
                        {c_reg, d_reg} <= pc1_perm(KEY);
                        round          <= 5'd1;
                        state          <= ROUND;
                    end
                end
                ROUND: begin
                    c_reg <= c_rot;
                    d_reg <= d_rot;
                    l_reg <= r_reg;
                    r_reg <= l_reg ^ f_out;
                    if (round == 5'd16) begin
                        state <= DONE;
                    end else begin
                        round <= round + 5'd1;
                    end
                end
                DONE: begin
                    // The final round is left unswapped, so R16 goes in the upper half.
                    cipher_text <= fp_perm({r_reg, l_reg});
                    dat_valid   <= 1'b1;
                    round       <= 5'd0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_encrypt_core.sv
module tb_des_encrypt_core;

  // Clock and reset block
  logic clk;
  logic rst_n;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Three engines with different build-time keys
  logic        start [3];
  logic [63:0] pt    [3];
  logic [63:0] ct    [3];
  logic        valid [3];

  des_encrypt_core #(.KEY(64'h133457799BBCDFF1)) dut0 (
    .clk(clk), .rst_n(rst_n), .plain_text(pt[0]), .start(start[0]),
    .cipher_text(ct[0]), .dat_valid(valid[0]));

  des_encrypt_core #(.KEY(64'h0000000000000000)) dut1 (
    .clk(clk), .rst_n(rst_n), .plain_text(pt[1]), .start(start[1]),
    .cipher_text(ct[1]), .dat_valid(valid[1]));

  des_encrypt_core #(.KEY(64'h0E329232EA6D0D73)) dut2 (
    .clk(clk), .rst_n(rst_n), .plain_text(pt[2]), .start(start[2]),
    .cipher_text(ct[2]), .dat_valid(valid[2]));

  // Scoreboard: expected ciphertext, owning engine, and cycle of its strobe
  logic [63:0] exp_q[$];
  int          exp_id_q[$];
  int          exp_cyc_q[$];
  int          n_cmp;
  int          n_err;

  localparam logic [63:0] PT_A = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT_A = 64'h85E813540F0AB405;
  localparam logic [63:0] CT_Z = 64'h8CA64DE9C1B123A7;
  localparam logic [63:0] PT_C = 64'h8787878787878787;

  // Monitor: every strobe must match the head of the queue in engine, data and cycle
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (valid[i] === 1'b1) begin
        if (exp_q.size() == 0 || exp_id_q[0] != i) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_valid inst=%0d cycle=%0d got ct=%h, no result required", i, cyc, ct[i]);
        end else begin
          logic [63:0] e_ct;
          int          e_cyc;
          e_ct  = exp_q.pop_front();
          e_cyc = exp_cyc_q.pop_front();
          void'(exp_id_q.pop_front());
          n_cmp++;
          if (ct[i] !== e_ct) begin
            n_err++;
            $display("FAIL ciphertext inst=%0d got %h required %h", i, ct[i], e_ct);
          end
          n_cmp++;
          if (cyc != e_cyc) begin
            n_err++;
            $display("FAIL latency inst=%0d strobe at cycle %0d required %0d", i, cyc, e_cyc);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s got %h required %h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s got %b required %b", name, act, req);
    end
  endtask

  task automatic clear_exp();
    exp_q.delete();
    exp_id_q.delete();
    exp_cyc_q.delete();
  endtask

  // One-cycle start; plaintext is scrambled afterwards to prove it is latched.
  task automatic issue(input int id, input logic [63:0] p, input logic [63:0] e);
    pt[id]    = p;
    start[id] = 1'b1;
    exp_q.push_back(e);
    exp_id_q.push_back(id);
    exp_cyc_q.push_back(cyc + 18);
    @(negedge clk);
    start[id] = 1'b0;
    pt[id]    = {$urandom, $urandom};
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_timeout got %0d pending results required 0", name, exp_q.size());
      clear_exp();
    end
  endtask

  initial begin
    cyc   = 0;
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      pt[i]    = '0;
    end

    // Reset for 3 clocks with start held high on engine 0
    rst_n    = 1'b1;
    start[0] = 1'b1;
    pt[0]    = PT_A;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check64($sformatf("reset_ct%0d", i), ct[i], 64'h0);
      check1($sformatf("reset_valid%0d", i), valid[i], 1'b0);
    end
    rst_n    = 1'b0;
    start[0] = 1'b0;
    repeat (25) @(negedge clk);
    check64("no_op_after_reset_ct0", ct[0], 64'h0);

    // Directed vectors on each key
    issue(0, PT_A, CT_A);
    wait_drain("vec_a");
    repeat (5) @(negedge clk);
    check64("hold_ct0", ct[0], CT_A);

    issue(1, 64'h0, CT_Z);
    wait_drain("vec_zero");

    issue(2, PT_C, 64'h0);
    wait_drain("vec_c");
    check64("vec_c_ct2", ct[2], 64'h0);

    // X on start in IDLE must not begin an operation
    start[1] = 1'bx;
    repeat (20) @(negedge clk);
    start[1] = 1'b0;
    check64("x_start_hold_ct1", ct[1], CT_Z);

    // start held high: results every 18 cycles, mid-operation plaintext changes ignored
    start[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(CT_A);
      exp_id_q.push_back(0);
      exp_cyc_q.push_back(cyc + 18 + 18 * k);
    end
    for (int k = 0; k < 3; k++) begin
      pt[0] = PT_A;
      @(negedge clk);
      pt[0] = {$urandom, $urandom};
      repeat (17) @(negedge clk);
    end
    start[0] = 1'b0;
    pt[0]    = PT_A;
    wait_drain("back_to_back");

    // Reset around round 8 aborts the operation
    issue(0, PT_A, CT_A);
    repeat (7) @(negedge clk);
    rst_n = 1'b1;
    clear_exp();
    repeat (2) @(negedge clk);
    check64("abort_ct0", ct[0], 64'h0);
    check1("abort_valid0", valid[0], 1'b0);
    rst_n = 1'b0;
    repeat (25) @(negedge clk);
    check64("abort_no_result_ct0", ct[0], 64'h0);

    // Fresh operation after the abort
    issue(0, PT_A, CT_A);
    wait_drain("after_abort");
    repeat (3) @(negedge clk);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_results got %0d required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
